// File: rtl/issue_int.sv
// Integer issue/execute stage: takes the ready head of the integer issue queue,
// evaluates a single-cycle ALU op, parks the result in a small FIFO and
// broadcasts it on the CDB whenever the arbiter grants the request.
module issue_int #(
    parameter int DEPTH  = 2,
    parameter int DATA_W = 32,
    parameter int TAG_W  = 6
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [3:0]        equeueint_opcode,
    input  logic [TAG_W-1:0]  equeueint_rdtag,
    input  logic [DATA_W-1:0] equeueint_rsdata,
    input  logic [DATA_W-1:0] equeueint_rtdata,
    input  logic              equeueint_ready,
    output logic              issueint_done,
    output logic              cdb_req,
    input  logic              cdb_grant,
    output logic              cdb_valid,
    output logic [TAG_W-1:0]  cdb_tag,
    output logic [DATA_W-1:0] cdb_data
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    typedef enum logic [3:0] {
        OP_ADD  = 4'd0,
        OP_SUB  = 4'd1,
        OP_AND  = 4'd2,
        OP_OR   = 4'd3,
        OP_XOR  = 4'd4,
        OP_NOR  = 4'd5,
        OP_SLT  = 4'd6,
        OP_SLTU = 4'd7,
        OP_SLL  = 4'd8,
        OP_SRL  = 4'd9,
        OP_SRA  = 4'd10,
        OP_LUI  = 4'd11
    } alu_op_e;

    logic [TAG_W-1:0]  tag_mem  [DEPTH];
    logic [DATA_W-1:0] data_mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  count;
    logic              full;
    logic              push;
    logic              pop;
    logic [4:0]        shamt;
    logic [DATA_W-1:0] alu_result;

    // Handshake: a full FIFO still accepts the head when a slot frees on the
    // same edge; reset masks everything so a stale entry never leaves the stage.
    assign full          = (count == FULL_CNT);
    assign cdb_req       = (count != '0) & ~reset;
    assign pop           = cdb_req & cdb_grant;
    assign push          = equeueint_ready & (~full | pop) & ~reset;
    assign issueint_done = push;
    assign cdb_valid     = pop;
    assign cdb_tag       = pop ? tag_mem[rd_ptr]  : '0;
    assign cdb_data      = pop ? data_mem[rd_ptr] : '0;
    assign shamt         = equeueint_rsdata[4:0];

    // Single-cycle ALU on the queue head; reserved opcodes yield zero.
    always_comb begin
        alu_result = '0;
        case (equeueint_opcode)
            OP_ADD:  alu_result = equeueint_rsdata + equeueint_rtdata;
            OP_SUB:  alu_result = equeueint_rsdata - equeueint_rtdata;
            OP_AND:  alu_result = equeueint_rsdata & equeueint_rtdata;
            OP_OR:   alu_result = equeueint_rsdata | equeueint_rtdata;
            OP_XOR:  alu_result = equeueint_rsdata ^ equeueint_rtdata;
            OP_NOR:  alu_result = ~(equeueint_rsdata | equeueint_rtdata);
            OP_SLT:  alu_result = {{(DATA_W-1){1'b0}},
                                   ($signed(equeueint_rsdata) < $signed(equeueint_rtdata))};
            OP_SLTU: alu_result = {{(DATA_W-1){1'b0}},
                                   (equeueint_rsdata < equeueint_rtdata)};
            OP_SLL:  alu_result = equeueint_rtdata << shamt;
            OP_SRL:  alu_result = equeueint_rtdata >> shamt;
            OP_SRA:  alu_result = $signed(equeueint_rtdata) >>> shamt;
            OP_LUI:  alu_result = equeueint_rtdata << 16;
            default: alu_result = '0;
        endcase
    end

    // Result storage: written at the tail on every accepted head.
    always_ff @(posedge clk) begin
        if (push) begin
            tag_mem[wr_ptr]  <= equeueint_rdtag;
            data_mem[wr_ptr] <= alu_result;
        end
    end

    // Pointer/occupancy bookkeeping; reset drops all buffered results.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: tb/tb_issue_int.sv
// Scoreboard bench for issue_int: the stimulus process emulates the issue
// queue and pushes hand-computed results; a monitor checks every broadcast.
module tb_issue_int;

    localparam int DEPTH  = 2;
    localparam int DATA_W = 32;
    localparam int TAG_W  = 6;

    typedef struct {
        logic [3:0]        op;
        logic [TAG_W-1:0]  tag;
        logic [DATA_W-1:0] rs;
        logic [DATA_W-1:0] rt;
        logic [DATA_W-1:0] exp;
    } instr_t;

    logic              clk = 1'b0;
    logic              reset;
    logic [3:0]        equeueint_opcode;
    logic [TAG_W-1:0]  equeueint_rdtag;
    logic [DATA_W-1:0] equeueint_rsdata;
    logic [DATA_W-1:0] equeueint_rtdata;
    logic              equeueint_ready;
    logic              issueint_done;
    logic              cdb_req;
    logic              cdb_grant;
    logic              cdb_valid;
    logic [TAG_W-1:0]  cdb_tag;
    logic [DATA_W-1:0] cdb_data;

    instr_t                    iq[$];
    logic [TAG_W+DATA_W-1:0]   sb[$];
    logic [TAG_W+DATA_W-1:0]   mon_exp;
    int tests_run    = 0;
    int tests_failed = 0;
    int n_bcast      = 0;

    issue_int #(.DEPTH(DEPTH), .DATA_W(DATA_W), .TAG_W(TAG_W)) dut (
        .clk              (clk),
        .reset            (reset),
        .equeueint_opcode (equeueint_opcode),
        .equeueint_rdtag  (equeueint_rdtag),
        .equeueint_rsdata (equeueint_rsdata),
        .equeueint_rtdata (equeueint_rtdata),
        .equeueint_ready  (equeueint_ready),
        .issueint_done    (issueint_done),
        .cdb_req          (cdb_req),
        .cdb_grant        (cdb_grant),
        .cdb_valid        (cdb_valid),
        .cdb_tag          (cdb_tag),
        .cdb_data         (cdb_data)
    );

    // Free-running clock, 10 time units per cycle.
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [63:0] actual,
                               input logic [63:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", name, actual, expected);
        end
    endtask

    task automatic add_instr(input logic [3:0] op, input logic [TAG_W-1:0] tag,
                             input logic [DATA_W-1:0] rs, input logic [DATA_W-1:0] rt,
                             input logic [DATA_W-1:0] exp);
        instr_t t;
        t.op  = op;
        t.tag = tag;
        t.rs  = rs;
        t.rt  = rt;
        t.exp = exp;
        iq.push_back(t);
    endtask

    // One clock cycle: present the queue head, check handshake outputs
    // mid-cycle, and retire the head into the scoreboard when it is taken.
    task automatic applyStimulus(input bit rdy_en, input bit grant, input bit exp_done,
                                 input bit exp_req, input bit exp_valid);
        instr_t head;
        head.op  = '0;
        head.tag = '0;
        head.rs  = '0;
        head.rt  = '0;
        head.exp = '0;
        if (rdy_en && iq.size() > 0) begin
            head = iq[0];
            equeueint_ready = 1'b1;
        end else begin
            equeueint_ready = 1'b0;
        end
        equeueint_opcode = head.op;
        equeueint_rdtag  = head.tag;
        equeueint_rsdata = head.rs;
        equeueint_rtdata = head.rt;
        cdb_grant        = grant;
        @(negedge clk);
        checkOutput("issueint_done", 64'(issueint_done), 64'(exp_done));
        checkOutput("cdb_req", 64'(cdb_req), 64'(exp_req));
        checkOutput("cdb_valid", 64'(cdb_valid), 64'(exp_valid));
        if (issueint_done && equeueint_ready) begin
            sb.push_back({head.tag, head.exp});
            void'(iq.pop_front());
        end
        @(posedge clk);
        #1;
    endtask

    // Monitor: every broadcast must match the oldest expected result; idle
    // cycles must show a zero tag and data.
    always @(negedge clk) begin
        if (cdb_valid) begin
            n_bcast++;
            if (sb.size() == 0) begin
                tests_run++;
                tests_failed++;
                $display("[TB] FAIL unexpected_bcast: got tag 0x%0h data 0x%0h, want no broadcast",
                         cdb_tag, cdb_data);
            end else begin
                mon_exp = sb.pop_front();
                checkOutput("cdb_tag", 64'(cdb_tag), 64'(mon_exp[TAG_W+DATA_W-1:DATA_W]));
                checkOutput("cdb_data", 64'(cdb_data), 64'(mon_exp[DATA_W-1:0]));
            end
        end else begin
            checkOutput("idle_tag", 64'(cdb_tag), 64'(0));
            checkOutput("idle_data", 64'(cdb_data), 64'(0));
        end
    end

    // Watchdog so the run always ends on its own.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got no finish, want finish before timeout");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        reset            = 1'b1;
        equeueint_ready  = 1'b0;
        equeueint_opcode = '0;
        equeueint_rdtag  = '0;
        equeueint_rsdata = '0;
        equeueint_rtdata = '0;
        cdb_grant        = 1'b0;
        @(posedge clk);
        #1;

        // Reset state, then idle with nothing ready.
        applyStimulus(0, 0, 0, 0, 0);
        applyStimulus(0, 1, 0, 0, 0);
        reset = 1'b0;
        for (int i = 0; i < 10; i++) applyStimulus(0, 0, 0, 0, 0);
        applyStimulus(0, 1, 0, 0, 0);
        applyStimulus(0, 1, 0, 0, 0);

        // Single ADD with grant present: broadcast the following cycle.
        add_instr(4'd0, 6'd5, 32'd5, 32'd7, 32'd12);
        applyStimulus(1, 1, 1, 0, 0);
        applyStimulus(1, 1, 0, 1, 1);
        applyStimulus(1, 1, 0, 0, 0);

        // Fill the FIFO with no grant, then drain while pushing into full.
        add_instr(4'd0, 6'd5, 32'd1,      32'd2,      32'd3);
        add_instr(4'd1, 6'd6, 32'd10,     32'd4,      32'd6);
        add_instr(4'd2, 6'd7, 32'hF0F0,   32'hFF00,   32'hF000);
        add_instr(4'd3, 6'd8, 32'h0F,     32'hF0,     32'hFF);
        applyStimulus(1, 0, 1, 0, 0);
        applyStimulus(1, 0, 1, 1, 0);
        applyStimulus(1, 0, 0, 1, 0);
        applyStimulus(1, 0, 0, 1, 0);
        applyStimulus(1, 1, 1, 1, 1);
        applyStimulus(1, 1, 1, 1, 1);
        applyStimulus(1, 1, 0, 1, 1);
        applyStimulus(1, 1, 0, 1, 1);
        applyStimulus(1, 1, 0, 0, 0);

        // Opcode coverage, streamed back to back with grant held.
        add_instr(4'd1,  6'd10, 32'd3,          32'd5,          32'hFFFF_FFFE);
        add_instr(4'd6,  6'd11, 32'hFFFF_FFFF,  32'd1,          32'd1);
        add_instr(4'd7,  6'd12, 32'hFFFF_FFFF,  32'd1,          32'd0);
        add_instr(4'd10, 6'd13, 32'd4,          32'h8000_0000,  32'hF800_0000);
        add_instr(4'd11, 6'd14, 32'd0,          32'h1234,       32'h1234_0000);
        add_instr(4'd4,  6'd15, 32'hFF00_FF00,  32'h0F0F_0F0F,  32'hF00F_F00F);
        add_instr(4'd5,  6'd16, 32'd0,          32'd0,          32'hFFFF_FFFF);
        add_instr(4'd8,  6'd17, 32'h1F,         32'd1,          32'h8000_0000);
        add_instr(4'd9,  6'd18, 32'h24,         32'hF0,         32'h0F);
        add_instr(4'd12, 6'd19, 32'd5,          32'd7,          32'd0);
        add_instr(4'd6,  6'd20, 32'd1,          32'hFFFF_FFFF,  32'd0);
        add_instr(4'd7,  6'd21, 32'd1,          32'hFFFF_FFFF,  32'd1);
        for (int i = 0; i < 12; i++) applyStimulus(1, 1, 1, (i > 0), (i > 0));
        applyStimulus(0, 1, 0, 1, 1);
        applyStimulus(0, 1, 0, 0, 0);

        // Reset with two results buffered: they must never be broadcast.
        add_instr(4'd0, 6'd30, 32'd1, 32'd1, 32'd2);
        add_instr(4'd0, 6'd31, 32'd2, 32'd2, 32'd4);
        applyStimulus(1, 0, 1, 0, 0);
        applyStimulus(1, 0, 1, 1, 0);
        add_instr(4'd0, 6'd32, 32'd9, 32'd9, 32'd18);
        reset = 1'b1;
        applyStimulus(1, 1, 0, 0, 0);
        sb.delete();
        iq.delete();
        reset = 1'b0;
        for (int i = 0; i < 3; i++) applyStimulus(0, 1, 0, 0, 0);

        // Normal operation resumes after reset.
        add_instr(4'd0, 6'd33, 32'd100, 32'd23, 32'd123);
        applyStimulus(1, 1, 1, 0, 0);
        applyStimulus(0, 1, 0, 1, 1);
        applyStimulus(0, 1, 0, 0, 0);

        checkOutput("sb_drained", 64'(sb.size()), 64'(0));
        checkOutput("iq_drained", 64'(iq.size()), 64'(0));
        checkOutput("bcast_count", 64'(n_bcast), 64'(18));

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
